// File: rtl/addsub_cmd_sequencer.sv
// Command front-end for the 4-bit adder/subtractor: buffers add/sub commands,
// issues them with a settle cycle, and captures results into a valid/ready register.
module addsub_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_a,
  input  logic [3:0]      in_b,
  input  logic            in_op,
  output logic [3:0]      add_a,
  output logic [3:0]      add_b,
  output logic            add_cin,
  input  logic [3:0]      add_s,
  input  logic            add_ca,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_s,
  output logic            out_ca,
  output logic            out_op,
  output logic [CNTW-1:0] done_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_CAPT} state_t;

  state_t      state;
  logic [8:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        res_free;
  logic        capture;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign res_free = !out_valid || out_ready;
  assign capture  = (state == S_CAPT) && res_free;
  assign pop      = !empty && ((state == S_EMPTY) || capture);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {in_a, in_b, in_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Issue register only changes on a pop, so the adder inputs stay stable through WAIT and CAPT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else begin
      if (pop) {add_a, add_b, add_cin} <= mem[rptr[AW-1:0]];
      case (state)
        S_EMPTY: if (pop) state <= S_WAIT;
        S_WAIT:  state <= S_CAPT;
        S_CAPT:  if (capture) state <= pop ? S_WAIT : S_EMPTY;
        default: state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_s      <= '0;
      out_ca     <= 1'b0;
      out_op     <= 1'b0;
      done_count <= '0;
    end else begin
      if (capture) begin
        out_valid <= 1'b1;
        out_s     <= add_s;
        out_ca    <= add_ca;
        out_op    <= add_cin;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) done_count <= done_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_addsub_cmd_sequencer.sv
// Self-checking bench for addsub_cmd_sequencer: directed and random command streams
// scored against an in-order queue of arithmetically computed results.
module tb_addsub_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_op;
  logic       out_ready;

  logic       in_ready, add_cin, add_ca, out_valid, out_ca, out_op;
  logic [3:0] add_a, add_b, add_s, out_s;
  logic [7:0] done_count;

  logic       in_ready_w, add_cin_w, add_ca_w, out_valid_w, out_ca_w, out_op_w;
  logic [3:0] add_a_w, add_b_w, add_s_w, out_s_w;
  logic [1:0] done_count_w;

  int         n_asserts = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         cnt_exp   = 0;
  logic       accepted  = 1'b0;
  logic [5:0] expq[$];
  logic [5:0] seen[$];
  int         hs_cyc[$];

  always #5 clk = ~clk;

  addsub_cmd_sequencer #(.DEPTH(4), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_ca(add_ca),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_ca(out_ca),
    .out_op(out_op), .done_count(done_count)
  );

  addsub_cmd_sequencer #(.DEPTH(4), .CNTW(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .add_a(add_a_w), .add_b(add_b_w), .add_cin(add_cin_w), .add_s(add_s_w), .add_ca(add_ca_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_s(out_s_w), .out_ca(out_ca_w),
    .out_op(out_op_w), .done_count(done_count_w)
  );

  // Returns {carry/borrow, result} of the external adder/subtractor.
  function automatic logic [4:0] arith(input logic [3:0] a, input logic [3:0] b, input logic op);
    int sum;
    logic [4:0] r;
    if (!op) begin
      sum = int'(a) + int'(b);
      r = {sum > 15, 4'(sum % 16)};
    end else if (a >= b) begin
      r = {1'b0, 4'(a - b)};
    end else begin
      r = {1'b1, 4'(b - a)};
    end
    return r;
  endfunction

  always_comb {add_ca, add_s} = arith(add_a, add_b, add_cin);
  always_comb {add_ca_w, add_s_w} = arith(add_a_w, add_b_w, add_cin_w);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scores handshakes at the negedge, then checks the completion counters after the edge.
  task automatic runCycle();
    logic [5:0] e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (accepted) expq.push_back({in_op, arith(in_a, in_b, in_op)});
    if (out_valid && out_ready) begin
      checkOutput("result_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("out_s", 32'(out_s), 32'(e[3:0]));
        checkOutput("out_ca", 32'(out_ca), 32'(e[4]));
        checkOutput("out_op", 32'(out_op), 32'(e[5]));
      end
      seen.push_back({out_op, out_ca, out_s});
      hs_cyc.push_back(cyc);
      cnt_exp++;
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("done_count", 32'(done_count), 32'(cnt_exp % 256));
    checkOutput("done_count_wrap", 32'(done_count_w), 32'(cnt_exp % 4));
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic op, input logic rdy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = rdy;
    runCycle();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((expq.size() != 0 || out_valid) && k < budget) begin
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      k++;
    end
    checkOutput("drain_complete", 32'(expq.size() == 0 && out_valid == 1'b0), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_add_a"}, 32'(add_a), 32'd0);
    checkOutput({tag, "_add_b"}, 32'(add_b), 32'd0);
    checkOutput({tag, "_add_cin"}, 32'(add_cin), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_s"}, 32'(out_s), 32'd0);
    checkOutput({tag, "_out_ca"}, 32'(out_ca), 32'd0);
    checkOutput({tag, "_out_op"}, 32'(out_op), 32'd0);
    checkOutput({tag, "_done_count"}, 32'(done_count), 32'd0);
    checkOutput({tag, "_done_count_wrap"}, 32'(done_count_w), 32'd0);
    checkOutput({tag, "_out_valid_wrap"}, 32'(out_valid_w), 32'd0);
  endtask

  initial begin
    logic [3:0] ca[7];
    logic [3:0] cb[7];
    logic       co[7];
    int         k;
    int         t;
    int         base;

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
    #2;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single add");
    applyStimulus(1'b1, 4'd5, 4'd3, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    checkOutput("issue_add_a", 32'(add_a), 32'd5);
    checkOutput("issue_add_b", 32'(add_b), 32'd3);
    checkOutput("issue_add_cin", 32'(add_cin), 32'd0);
    checkOutput("issue_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    checkOutput("settle_add_a", 32'(add_a), 32'd5);
    checkOutput("settle_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    checkOutput("capt_out_valid", 32'(out_valid), 32'd1);
    checkOutput("capt_out_s", 32'(out_s), 32'd8);
    checkOutput("capt_out_ca", 32'(out_ca), 32'd0);
    checkOutput("capt_out_op", 32'(out_op), 32'd0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    checkOutput("single_done_count", 32'(done_count), 32'd1);
    checkOutput("single_out_valid_clear", 32'(out_valid), 32'd0);

    $display("[TB] back-to-back overflow and subtracts");
    seen.delete();
    hs_cyc.delete();
    applyStimulus(1'b1, 4'd9, 4'd9, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd7, 4'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'd3, 4'd7, 1'b1, 1'b1);
    drain(30);
    checkOutput("b2b_count", 32'(seen.size()), 32'd3);
    if (seen.size() >= 3) begin
      checkOutput("b2b_res0", 32'(seen[0]), 32'h12);
      checkOutput("b2b_res1", 32'(seen[1]), 32'h24);
      checkOutput("b2b_res2", 32'(seen[2]), 32'h34);
      checkOutput("b2b_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
      checkOutput("b2b_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    end

    $display("[TB] backpressure and push at full occupancy");
    for (int i = 0; i < 7; i++) begin
      ca[i] = 4'($urandom_range(15));
      cb[i] = 4'($urandom_range(15));
      co[i] = 1'($urandom_range(1));
    end
    base = cnt_exp;
    k = 0;
    t = 0;
    while (k < 6 && t < 30) begin
      applyStimulus(1'b1, ca[k], cb[k], co[k], 1'b0);
      if (accepted) k++;
      t++;
    end
    checkOutput("bp_accepted", 32'(k), 32'd6);
    checkOutput("bp_no_refusal", 32'(t), 32'd6);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b1, ca[6], cb[6], co[6], 1'b0);
    checkOutput("bp_full_refused", 32'(accepted), 32'd0);
    applyStimulus(1'b1, ca[6], cb[6], co[6], 1'b1);
    checkOutput("bp_pop_cycle_refused", 32'(accepted), 32'd0);
    applyStimulus(1'b1, ca[6], cb[6], co[6], 1'b1);
    checkOutput("bp_after_space_accepted", 32'(accepted), 32'd1);
    drain(60);
    checkOutput("bp_done_total", 32'(done_count), 32'((base + 7) % 256));

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                    1'($urandom_range(1)), ($urandom_range(3) != 0));
    end
    drain(100);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 4'd2, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd6, 4'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    checkResetOutputs("midreset");
    expq.delete();
    cnt_exp = 0;
    #1;
    rst_n = 1'b1;
    seen.delete();
    applyStimulus(1'b1, 4'd1, 4'd1, 1'b0, 1'b1);
    drain(20);
    checkOutput("post_reset_count", 32'(seen.size()), 32'd1);
    if (seen.size() >= 1) checkOutput("post_reset_result", 32'(seen[0]), 32'h02);

    $display("[TB] counter wrap");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'(i), 4'd2, 1'b0, 1'b1);
      drain(20);
    end
    checkOutput("wrap_final", 32'(done_count_w), 32'd1);
    checkOutput("wrap_wide_final", 32'(done_count), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_cmd_sequencer.md
# addsub_cmd_sequencer

Command front-end for the 4-bit adder/subtractor. It accepts add/sub commands over a valid/ready input, buffers them in a small FIFO and drives operands and mode (`add_a`, `add_b`, `add_cin`) to the adder/subtractor. It holds the operands stable for one full settle cycle, then captures the returned sum/magnitude and carry/borrow (`add_s`, `add_ca`) into a valid/ready result register. It sits directly upstream of the adder/subtractor and also consumes its outputs.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `CNTW`, 8: width of the completion counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  FIFO not full.
- `in_a`  in  4  operand A.
- `in_b`  in  4  operand B.
- `in_op`  in  1  0 = add, 1 = subtract.
- `add_a`  out  4  operand A to the adder/subtractor.
- `add_b`  out  4  operand B to the adder/subtractor.
- `add_cin`  out  1  mode to the adder/subtractor (= op).
- `add_s`  in  4  adder/subtractor result.
- `add_ca`  in  1  adder/subtractor carry (add) or borrow (sub).
- `out_valid`  out  1  result register full.
- `out_ready`  in  1  downstream accepts the result.
- `out_s`  out  4  captured result.
- `out_ca`  out  1  captured carry/borrow.
- `out_op`  out  1  op of the captured result.
- `done_count`  out  CNTW  results handed off downstream; wraps modulo 2^CNTW.

## Operation
- Reset (async assert, sync release): FIFO empty; issue FSM = EMPTY; `in_ready`=1; `add_a`=0, `add_b`=0, `add_cin`=0; `out_valid`=0, `out_s`=0, `out_ca`=0, `out_op`=0; `done_count`=0. In-flight commands are discarded.
- FIFO push occurs on `in_valid && in_ready`. `in_ready` = !full. A push is never accepted while full, even if a pop happens in the same cycle.
- The issue register holds {a, b, op} and drives `add_a`, `add_b`, `add_cin` directly from flops. Its contents change only on a pop.
- Issue FSM:
  - EMPTY: if the FIFO is non-empty, pop into the issue register and go to WAIT.
  - WAIT: go to CAPT unconditionally. This gives the adder/subtractor one full cycle of stable inputs.
  - CAPT: define `res_free` = !out_valid || out_ready.
    - If `res_free`: load `add_s`, `add_ca` and the issued op into the result register and set `out_valid`=1. Then, if the FIFO is non-empty, pop and go to WAIT; otherwise go to EMPTY.
    - If !`res_free`: stay in CAPT with operands held.
- Result register: `out_valid` clears on `out_valid && out_ready` unless a capture happens in the same cycle, in which case it reloads and stays at 1.
- `done_count` increments by one on each `out_valid && out_ready`.
- Pass-through arithmetic from the adder/subtractor:
  - add: `add_s` = (A+B) mod 16, `add_ca` = carry-out.
  - sub: `add_s` = |A−B|, `add_ca` = 1 iff A<B.
  - The block does not check or modify these values.

## Timing
- Minimum latency: push at edge 0 → pop/issue at edge 1 → CAPT at edge 2 → capture at edge 3. `out_valid` is high in the cycle after edge 3.
- Throughput: one result per 2 cycles when `out_ready`=1 continuously.
- `add_*` outputs are glitch-free, register outputs, constant from a pop until the next pop.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits are equal; empty = pointers equal.
- Simultaneous FIFO push and pop when not full and not empty: both take effect; occupancy is unchanged.
- Push into an empty FIFO while the FSM is in EMPTY: the pop happens no earlier than the next edge. There is no bypass.
- Backpressure (`out_ready`=0 with `out_valid`=1): the FSM holds in CAPT and the FIFO fills. `in_ready` drops after DEPTH further pushes. No command is lost or reordered.
- `rst_n` asserted mid-operation: all outputs immediately take their reset values, independent of `clk`.

## Test plan
- Single add, A=5, B=3, op=0, `out_ready`=1: `add_a`=5, `add_b`=3, `add_cin`=0 from edge 1. Then `out_valid`=1 with `out_s`=8, `out_ca`=0, `out_op`=0 after edge 3; `done_count`=1.
- Add overflow and subtracts, back-to-back:
  - (9,9,add) → `out_s`=2, `out_ca`=1.
  - (7,3,sub) → `out_s`=4, `out_ca`=0.
  - (3,7,sub) → `out_s`=4, `out_ca`=1.
  - Results emerge in order, one every 2 cycles.
- Backpressure: hold `out_ready`=0 and push 6 commands with DEPTH=4.
  - `in_ready` falls after 4 FIFO pushes (1 in issue, 1 in result).
  - After `out_ready` is released, all 6 results emerge in order and `done_count`=6.
- Simultaneous push and pop at full occupancy: `in_ready`=0, so the push is refused. The command is accepted the cycle after space frees and no FIFO entry is duplicated.
- Reset mid-stream: assert `rst_n`=0 between clock edges with 3 commands in flight.
  - All outputs are 0 and `in_ready`=1 immediately.
  - After release, a new (1,1,add) yields `out_s`=2 with no stale results.
- Counter wrap with CNTW=2: 5 handoffs → `done_count` sequence 1, 2, 3, 0, 1.
